mips_load_store_unit: RTL and testbench

Load/store unit between the MIPS datapath and the byte-addressed, big-endian `mips_memory`. It accepts one load/store request at a time and drives the memory's `address`/`wr_en`/`read_en`/`byte_en`/`data_in` ports. For loads, it waits out the memory's registered read latency, then extracts, extends and merges the returned word into a 32-bit result. It detects misaligned and illegal operations without touching memory.

---
 rtl/mips_load_store_unit_if.sv | 21 ++
 rtl/mips_load_store_unit.sv | 187 ++++++++++++++++++
 tb/tb_mips_load_store_unit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_load_store_unit_if.sv
// rtl/mips_load_store_unit_if.sv - request/response bundle between the MIPS datapath and the load/store unit
interface mips_load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/mips_load_store_unit.sv
// rtl/mips_load_store_unit.sv - single-outstanding MIPS load/store unit for a big-endian registered-read memory
module mips_load_store_unit #(
    parameter int READ_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    mips_load_store_unit_if.slave       lsu,
    output logic [31:0]                 mem_address,
    output logic                        mem_wr_en,
    output logic                        mem_read_en,
    output logic [3:0]                  mem_byte_en,
    output logic [31:0]                 mem_data_in,
    input  logic [31:0]                 mem_data_out
);
    localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q;
    logic [3:0]  op_q;
    logic [1:0]  a_q;
    logic [31:0] wdata_q;
    logic [1:0]  cnt_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_error_q;
    logic [31:0] mem_address_q;
    logic        mem_wr_en_q;
    logic        mem_read_en_q;
    logic [3:0]  mem_byte_en_q;
    logic [31:0] mem_data_in_q;

    logic [1:0]  req_a;
    logic        req_load_d;
    logic        req_store_d;
    logic        req_err_d;
    logic [3:0]  st_be_d;
    logic [31:0] st_data_d;

    // Decode of the incoming request, consumed only on the accepting edge.
    always_comb begin
        req_a       = lsu.req_addr[1:0];
        req_load_d  = (lsu.req_op <= 4'd6);
        req_store_d = (lsu.req_op == 4'd8) || (lsu.req_op == 4'd9) || (lsu.req_op == 4'd11);
        req_err_d   = !(req_load_d || req_store_d)
                   || (((lsu.req_op == 4'd1) || (lsu.req_op == 4'd5) || (lsu.req_op == 4'd9)) && req_a[0])
                   || (((lsu.req_op == 4'd3) || (lsu.req_op == 4'd11)) && (req_a != 2'd0));
        st_be_d   = 4'b0000;
        st_data_d = 32'd0;
        case (lsu.req_op)
            4'd8: begin
                st_be_d   = 4'b0001 << req_a;
                st_data_d = {4{lsu.req_wdata[7:0]}};
            end
            4'd9: begin
                st_be_d   = 4'b0011 << req_a;
                st_data_d = {2{lsu.req_wdata[15:0]}};
            end
            4'd11: begin
                st_be_d   = 4'b1111;
                st_data_d = lsu.req_wdata;
            end
            default: ;
        endcase
    end

    logic [4:0]  sh_lane;
    logic [4:0]  sh_left;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_data_d;

    // Lane a sits at bits [31-8a -: 8], so shifting right by 8*(3-a) brings it to the bottom.
    always_comb begin
        sh_lane = {~a_q, 3'b000};
        sh_left = {a_q, 3'b000};
        byte_v  = 8'(mem_data_out >> sh_lane);
        half_v  = 16'(mem_data_out >> {~a_q[1], 4'b0000});
        case (op_q)
            4'd0:    load_data_d = {{24{byte_v[7]}}, byte_v};
            4'd4:    load_data_d = {24'd0, byte_v};
            4'd1:    load_data_d = {{16{half_v[15]}}, half_v};
            4'd5:    load_data_d = {16'd0, half_v};
            4'd3:    load_data_d = mem_data_out;
            4'd2:    load_data_d = (mem_data_out << sh_left)
                                 | (wdata_q & ~(32'hFFFF_FFFF << sh_left));
            4'd6:    load_data_d = (mem_data_out >> sh_lane)
                                 | (wdata_q & ~(32'hFFFF_FFFF >> sh_lane));
            default: load_data_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            op_q          <= 4'd0;
            a_q           <= 2'd0;
            wdata_q       <= 32'd0;
            cnt_q         <= 2'd0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'd0;
            resp_error_q  <= 1'b0;
            mem_address_q <= 32'd0;
            mem_wr_en_q   <= 1'b0;
            mem_read_en_q <= 1'b0;
            mem_byte_en_q <= 4'd0;
            mem_data_in_q <= 32'd0;
        end else begin
            mem_wr_en_q   <= 1'b0;
            mem_read_en_q <= 1'b0;
            mem_byte_en_q <= 4'd0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= 32'd0;
            resp_error_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (lsu.req_valid) begin
                        req_ready_q <= 1'b0;
                        op_q        <= lsu.req_op;
                        a_q         <= req_a;
                        wdata_q     <= lsu.req_wdata;
                        if (req_err_d) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                        end else begin
                            state_q       <= S_ACCESS;
                            mem_address_q <= {lsu.req_addr[31:2], 2'b00};
                            if (req_store_d) begin
                                mem_wr_en_q   <= 1'b1;
                                mem_byte_en_q <= st_be_d;
                                mem_data_in_q <= st_data_d;
                            end else begin
                                mem_read_en_q <= 1'b1;
                                mem_byte_en_q <= 4'b1111;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    // Only stores carry opcode bit 3 once errors have been filtered out.
                    if (op_q[3]) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                    end else begin
                        state_q <= S_WAIT;
                        cnt_q   <= LAT_M1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 2'd0) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_data_d;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign lsu.req_ready  = req_ready_q;
    assign lsu.resp_valid = resp_valid_q;
    assign lsu.resp_rdata = resp_rdata_q;
    assign lsu.resp_error = resp_error_q;
    assign mem_address    = mem_address_q;
    assign mem_wr_en      = mem_wr_en_q;
    assign mem_read_en    = mem_read_en_q;
    assign mem_byte_en    = mem_byte_en_q;
    assign mem_data_in    = mem_data_in_q;
endmodule

// File: tb/tb_mips_load_store_unit.sv
// tb/tb_mips_load_store_unit.sv - scoreboard bench for mips_load_store_unit against a byte-array memory model
module tb_mips_load_store_unit;
    localparam int L = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_init = 1'b1;
    logic [31:0] mem_address;
    logic        mem_wr_en;
    logic        mem_read_en;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    always #5 clk = ~clk;

    mips_load_store_unit_if bus ();

    mips_load_store_unit #(.READ_LATENCY(L)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .lsu          (bus),
        .mem_address  (mem_address),
        .mem_wr_en    (mem_wr_en),
        .mem_read_en  (mem_read_en),
        .mem_byte_en  (mem_byte_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h0101_0101) ^ 32'h5A3C_0F96;
    endfunction

    logic [31:0] mem_w [0:15];
    always @(posedge clk) begin : memory
        logic [31:0] nw;
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem_w[i] <= init_word(i);
        end else begin
            if (mem_wr_en) begin
                nw = mem_w[mem_address[5:2]];
                for (int k = 0; k < 4; k++)
                    if (mem_byte_en[k]) nw[31-8*k -: 8] = mem_data_in[31-8*k -: 8];
                mem_w[mem_address[5:2]] <= nw;
            end
            if (mem_read_en) mem_data_out <= mem_w[mem_address[5:2]];
        end
    end

    typedef struct { logic [31:0] rdata; logic err; int due; } resp_t;
    typedef struct { logic wr; logic [31:0] addr; logic [3:0] be; logic [31:0] data; int due; } strb_t;
    resp_t rq[$];
    strb_t sq[$];
    logic [7:0] mdl [0:63];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response/strobe the DUT shows must match the oldest expectation, on time.
    initial forever begin
        resp_t r;
        strb_t s;
        @(negedge clk);
        while (rq.size() > 0 && rq[0].due < cyc) begin
            r = rq.pop_front();
            check("resp_missing", 32'(cyc), 32'(r.due));
        end
        while (sq.size() > 0 && sq[0].due < cyc) begin
            s = sq.pop_front();
            check("strobe_missing", 32'(cyc), 32'(s.due));
        end
        if (bus.resp_valid) begin
            if (rq.size() == 0) begin
                check("resp_unexpected", 32'(bus.resp_valid), 32'd0);
            end else begin
                r = rq.pop_front();
                check("resp_rdata", bus.resp_rdata, r.rdata);
                check("resp_error", 32'(bus.resp_error), 32'(r.err));
                check("resp_cycle", 32'(cyc), 32'(r.due));
            end
        end else begin
            check("idle_rdata", bus.resp_rdata, 32'd0);
            check("idle_error", 32'(bus.resp_error), 32'd0);
        end
        if (mem_wr_en || mem_read_en) begin
            if (sq.size() == 0) begin
                check("strobe_unexpected", 32'(mem_wr_en | mem_read_en), 32'd0);
            end else begin
                s = sq.pop_front();
                check("mem_wr_en", 32'(mem_wr_en), 32'(s.wr));
                check("mem_read_en", 32'(mem_read_en), 32'(!s.wr));
                check("mem_address", mem_address, s.addr);
                check("mem_byte_en", 32'(mem_byte_en), 32'(s.be));
                if (s.wr) check("mem_data_in", mem_data_in, s.data);
                check("strobe_cycle", 32'(cyc), 32'(s.due));
            end
        end else begin
            check("idle_byte_en", 32'(mem_byte_en), 32'd0);
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input bit use_c, input logic [31:0] c);
        int n;
        int acc;
        int nb;
        int sh;
        logic [1:0]  a;
        logic [31:0] base, w, v, res;
        logic [3:0]  be;
        logic is_ld, is_st, err;
        strb_t s;
        resp_t r;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        acc = cyc;
        bus.req_valid = 1'b0;

        a     = addr[1:0];
        base  = addr & ~32'h3;
        is_ld = (op <= 4'd6);
        is_st = (op == 4'd8) || (op == 4'd9) || (op == 4'd11);
        err   = !(is_ld || is_st) || (((op == 4'd1) || (op == 4'd5) || (op == 4'd9)) && a[0])
             || (((op == 4'd3) || (op == 4'd11)) && (a != 2'd0));
        if (err) begin
            r = '{rdata: 32'd0, err: 1'b1, due: acc};
            rq.push_back(r);
        end else if (is_st) begin
            nb = (op == 4'd8) ? 1 : (op == 4'd9) ? 2 : 4;
            be = 4'd0;
            for (int i = 0; i < nb; i++) begin
                mdl[addr + 32'(i)] = 8'(wd >> (8 * (nb - 1 - i)));
                be[addr[1:0] + 2'(i)] = 1'b1;
            end
            v = (op == 4'd8) ? {4{wd[7:0]}} : (op == 4'd9) ? {2{wd[15:0]}} : wd;
            s = '{wr: 1'b1, addr: base, be: be, data: v, due: acc};
            sq.push_back(s);
            r = '{rdata: 32'd0, err: 1'b0, due: acc + 1};
            rq.push_back(r);
        end else begin
            w = {mdl[base], mdl[base+1], mdl[base+2], mdl[base+3]};
            case (op)
                4'd0:    res = 32'(signed'(mdl[addr]));
                4'd4:    res = 32'(mdl[addr]);
                4'd1:    res = 32'(signed'({mdl[addr], mdl[addr+1]}));
                4'd5:    res = 32'({mdl[addr], mdl[addr+1]});
                4'd2: begin
                    sh  = 8 * int'(a);
                    res = (w << sh) | (wd & 32'((64'd1 << sh) - 64'd1));
                end
                4'd6: begin
                    sh  = 8 * (3 - int'(a));
                    res = (w >> sh) | (wd & ~(32'hFFFF_FFFF >> sh));
                end
                default: res = w;
            endcase
            s = '{wr: 1'b0, addr: base, be: 4'hF, data: 32'd0, due: acc};
            sq.push_back(s);
            r = '{rdata: use_c ? c : res, err: 1'b0, due: acc + 1 + L};
            rq.push_back(r);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0]  legal [10];
        logic [3:0]  op;
        logic [31:0] addr;
        legal = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd11};
        for (int i = 0; i < 16; i++)
            for (int k = 0; k < 4; k++) mdl[4*i+k] = 8'(init_word(i) >> (24 - 8*k));

        bus.req_valid = 1'b1;
        bus.req_op    = 4'd11;
        bus.req_addr  = 32'd8;
        bus.req_wdata = 32'hDEAD_BEEF;
        repeat (2) begin
            @(negedge clk);
            check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
            check("rst_mem_read_en", 32'(mem_read_en), 32'd0);
            check("rst_mem_address", mem_address, 32'd0);
            check("rst_mem_data_in", mem_data_in, 32'd0);
            check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
            check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        end
        bus.req_valid = 1'b0;
        mem_init = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

        issue(4'd11, 32'd8,  32'h1234_5678, 1'b0, 32'd0);
        issue(4'd3,  32'd8,  32'd0,         1'b1, 32'h1234_5678);
        issue(4'd8,  32'd9,  32'h0000_00AB, 1'b0, 32'd0);
        issue(4'd0,  32'd9,  32'd0,         1'b1, 32'hFFFF_FFAB);
        issue(4'd4,  32'd9,  32'd0,         1'b1, 32'h0000_00AB);
        issue(4'd9,  32'd10, 32'h0000_8001, 1'b0, 32'd0);
        issue(4'd1,  32'd10, 32'd0,         1'b1, 32'hFFFF_8001);
        issue(4'd5,  32'd10, 32'd0,         1'b1, 32'h0000_8001);
        issue(4'd3,  32'd8,  32'd0,         1'b1, 32'h12AB_8001);
        issue(4'd2,  32'd9,  32'hAAAA_AAAA, 1'b1, 32'hAB80_01AA);
        issue(4'd6,  32'd9,  32'hAAAA_AAAA, 1'b1, 32'hAAAA_12AB);
        issue(4'd3,  32'd6,  32'd0,         1'b0, 32'd0);
        issue(4'd9,  32'd5,  32'h1111_2222, 1'b0, 32'd0);
        issue(4'd7,  32'd0,  32'd0,         1'b0, 32'd0);

        // Reset while the load is in WAIT: response dropped, IDLE right after the reset edge.
        issue(4'd3, 32'd16, 32'd0, 1'b0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        void'(rq.pop_back());
        @(negedge clk);
        check("wait_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("wait_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        reset_n = 1'b1;

        // Reset while the store strobe is up: strobe must fall on the reset edge.
        issue(4'd11, 32'd20, 32'hCAFE_F00D, 1'b0, 32'd0);
        reset_n = 1'b0;
        void'(rq.pop_back());
        @(negedge clk);
        @(negedge clk);
        check("acc_rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        check("acc_rst_req_ready", 32'(bus.req_ready), 32'd1);
        reset_n = 1'b1;

        for (int n = 0; n < 300; n++) begin
            op   = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 9)] : 4'($urandom_range(0, 15));
            addr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) addr[0] = 1'b0;
            if ($urandom_range(0, 1) == 1 && (op == 4'd3 || op == 4'd11)) addr[1] = 1'b0;
            issue(op, addr, $urandom, 1'b0, 32'd0);
        end

        repeat (8) @(negedge clk);
        check("resp_queue_drained", 32'(rq.size()), 32'd0);
        check("strobe_queue_drained", 32'(sq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
